// File: rtl/lut_cfg_loader.sv
// Deserializes a byte-wide LUT config stream (SYNC, COUNT, N x 5-byte frames, CHK) into 33-bit frame writes.
// Optional macro CFG_CHECKSUM_EN adds the trailing CHK byte and its verification before done/fabric_en.
module lut_cfg_loader #(
    parameter int          NUM_LUTS  = 7,
    parameter int          ADDR_W    = 3,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [32:0]       cfg_data,
    output logic              done,
    output logic              error,
    output logic              fabric_en
);

    typedef enum logic [2:0] {HUNT, COUNT, FRAME, CHECK, DONE, ERR} state_t;

    localparam logic [7:0] MAX_N = 8'(NUM_LUTS);

    state_t              state, state_nxt;
    logic [7:0]          n_frames, n_frames_nxt;
    logic [7:0]          lut_idx, lut_idx_nxt;
    logic [2:0]          byte_idx, byte_idx_nxt;
    logic [7:0]          chk, chk_nxt;
    logic [31:0]         lut_buf, lut_buf_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [32:0]         data_nxt;
    logic                done_nxt, error_nxt;

    // Every state consumes bytes, so the loader never stalls the source.
    assign in_ready  = 1'b1;
    assign fabric_en = done;

    always_comb begin
        state_nxt    = state;
        n_frames_nxt = n_frames;
        lut_idx_nxt  = lut_idx;
        byte_idx_nxt = byte_idx;
        chk_nxt      = chk;
        lut_buf_nxt  = lut_buf;
        we_nxt       = 1'b0;
        addr_nxt     = cfg_addr;
        data_nxt     = cfg_data;
        done_nxt     = done;
        error_nxt    = error;

        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_data == SYNC_BYTE) state_nxt = COUNT;
                end
                COUNT: begin
                    if (in_data == 8'd0 || in_data > MAX_N) begin
                        state_nxt = ERR;
                        error_nxt = 1'b1;
                        done_nxt  = 1'b0;
                    end else begin
                        n_frames_nxt = in_data;
                        chk_nxt      = in_data;
                        lut_idx_nxt  = 8'd0;
                        byte_idx_nxt = 3'd0;
                        state_nxt    = FRAME;
                    end
                end
                FRAME: begin
                    chk_nxt = chk ^ in_data;
                    if (byte_idx == 3'd4) begin
                        // Only b4 bit 0 is frame content; its upper bits only feed the checksum.
                        we_nxt       = 1'b1;
                        addr_nxt     = lut_idx[ADDR_W-1:0];
                        data_nxt     = {in_data[0], lut_buf};
                        lut_idx_nxt  = lut_idx + 8'd1;
                        byte_idx_nxt = 3'd0;
                        if (lut_idx == n_frames - 8'd1) begin
`ifdef CFG_CHECKSUM_EN
                            state_nxt = CHECK;
`else
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
`endif
                        end
                    end else begin
                        lut_buf_nxt[{byte_idx[1:0], 3'b000} +: 8] = in_data;
                        byte_idx_nxt = byte_idx + 3'd1;
                    end
                end
`ifdef CFG_CHECKSUM_EN
                CHECK: begin
                    if (in_data == chk) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        error_nxt = 1'b1;
                    end
                end
`endif
                DONE, ERR: begin
                    if (in_data == SYNC_BYTE) begin
                        state_nxt = COUNT;
                        done_nxt  = 1'b0;
                        error_nxt = 1'b0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            n_frames <= 8'd0;
            lut_idx  <= 8'd0;
            byte_idx <= 3'd0;
            chk      <= 8'd0;
            lut_buf  <= 32'd0;
            cfg_we   <= 1'b0;
            cfg_addr <= '0;
            cfg_data <= 33'd0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            n_frames <= n_frames_nxt;
            lut_idx  <= lut_idx_nxt;
            byte_idx <= byte_idx_nxt;
            chk      <= chk_nxt;
            lut_buf  <= lut_buf_nxt;
            cfg_we   <= we_nxt;
            cfg_addr <= addr_nxt;
            cfg_data <= data_nxt;
            done     <= done_nxt;
            error    <= error_nxt;
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Randomized bench for lut_cfg_loader: a stream-level parser model predicts writes and final flags.
module tb_lut_cfg_loader;

`ifdef CFG_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [32:0] cfg_data;
    logic        done;
    logic        error;
    logic        fabric_en;

    lut_cfg_loader #(.NUM_LUTS(7), .ADDR_W(3), .SYNC_BYTE(8'hA5)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .done(done), .error(error), .fabric_en(fabric_en)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  stim[$];
    logic [40:0] got[$];
    logic [40:0] exp_w[$];
    bit          exp_done = 1'b0;
    bit          exp_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    always @(negedge clock) if (cfg_we === 1'b1) got.push_back({8'(cfg_addr), cfg_data});

    // Parse the whole stream by the format rules: locate sync, read count, slice frames, verify CHK.
    task automatic model();
        int i = 0;
        logic [7:0]  n, c;
        logic [32:0] d;
        exp_w.delete();
        while (i < stim.size() && stim[i] != 8'hA5) i++;
        if (i >= stim.size()) return;
        i++;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = stim[i];
        i++;
        if (n == 0 || n > 7) begin
            exp_err = 1'b1;
            return;
        end
        c = n;
        for (int k = 0; k < int'(n); k++) begin
            d = {stim[i+4][0], stim[i+3], stim[i+2], stim[i+1], stim[i]};
            for (int j = 0; j < 5; j++) c ^= stim[i+j];
            exp_w.push_back({8'(k), d});
            i += 5;
        end
        if (CHK_EN) begin
            exp_done = (stim[i] == c);
            exp_err  = !exp_done;
        end else begin
            exp_done = 1'b1;
        end
    endtask

    // pat=1: b0=index, rest zero; pat=0: random bytes.
    task automatic make_stream(input int n, input bit bad_chk, input bit pat);
        logic [7:0] c, b;
        stim.delete();
        stim.push_back(8'hA5);
        stim.push_back(8'(n));
        if (n >= 1 && n <= 7) begin
            c = 8'(n);
            for (int k = 0; k < n; k++)
                for (int j = 0; j < 5; j++) begin
                    b = pat ? ((j == 0) ? 8'(k) : 8'h00) : 8'($urandom);
                    stim.push_back(b);
                    c ^= b;
                end
            if (bad_chk) c ^= 8'($urandom_range(1, 255));
            if (CHK_EN) stim.push_back(c);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_data = 8'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_stream(input string tag, input int maxgap);
        got.delete();
        model();
        foreach (stim[i]) send_byte(stim[i], $urandom_range(0, maxgap));
        @(negedge clock);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, error, exp_err);
        check({tag, "_fen"}, fabric_en, exp_done);
`ifndef CFG_CHECKSUM_EN
        if (exp_done) check({tag, "_we_with_done"}, cfg_we, 1'b1);
`endif
        repeat (3) @(negedge clock);
        check({tag, "_nwr"}, got.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), got[i], exp_w[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, cfg_we, 1'b0);
        check({tag, "_addr"}, cfg_addr, 3'd0);
        check({tag, "_data"}, cfg_data, 33'd0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, error, 1'b0);
        check({tag, "_fen"}, fabric_en, 1'b0);
        check({tag, "_rdy"}, in_ready, 1'b1);
    endtask

    initial begin
        int n;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        #12;
        check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        stim = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        if (!CHK_EN) void'(stim.pop_back());
        run_stream("s1", 0);
        if (got.size() > 0) check("s1_frame", got[0], {8'd0, 33'h1_0000_0001});

        make_stream(7, 1'b0, 1'b1);
        run_stream("s2", 0);

        if (CHK_EN) begin
            stim = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
            run_stream("s3bad", 0);
            stim = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
            run_stream("s3good", 0);
        end

        make_stream(8, 1'b0, 1'b1);
        run_stream("s4big", 0);
        make_stream(0, 1'b0, 1'b1);
        run_stream("s4zero", 0);

        make_stream(7, 1'b0, 1'b1);
        stim.push_front(8'hFF);
        stim.push_front(8'h3C);
        run_stream("s5gap", 3);

        // Reset partway through the second frame.
        make_stream(7, 1'b0, 1'b0);
        got.delete();
        model();
        for (int i = 0; i < 10; i++) send_byte(stim[i], 0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_vals("s6rst");
        @(negedge clock);
        reset = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clock);
        check("s6_nwr", got.size(), 1);
        if (got.size() > 0) check("s6_wr0", got[0], exp_w[0]);
        run_stream("s6again", 1);

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 5) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(8, 255);
            else n = $urandom_range(1, 7);
            make_stream(n, ($urandom_range(0, 3) == 0), 1'b0);
            for (int g = $urandom_range(0, 2); g > 0; g--) stim.push_front(8'($urandom_range(0, 8'hA4)));
            run_stream($sformatf("rnd%0d", t), 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
